regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
Writeback controller and scoreboard for the 32-entry general-purpose register file. It arbitrates two writeback sources onto the register file's single write port: EXU (ALU results) and LSU (load data). It tracks registers with in-flight writes and reports read-after-write hazards and write-after-write issue stalls to the decode stage. It sits between EXU/LSU writeback and the register file's wen/waddr/wdata inputs.

Parameters:
ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers tracked
DATA_WIDTH, 64, writeback data width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
issue_valid  in  1  decode issues an instruction that will write issue_rd
issue_rd  in  ADDR_WIDTH  destination register of issuing instruction
issue_ready  out  1  issue accepted this cycle when issue_valid && issue_ready
rs1_addr  in  ADDR_WIDTH  decode source 1 index
rs2_addr  in  ADDR_WIDTH  decode source 2 index
rs1_hazard  out  1  rs1 has a pending write
rs2_hazard  out  1  rs2 has a pending write
exu_valid  in  1  EXU writeback request
exu_rd  in  ADDR_WIDTH  EXU destination
exu_data  in  DATA_WIDTH  EXU result
exu_ready  out  1  EXU request granted this cycle
lsu_valid  in  1  LSU writeback request
lsu_rd  in  ADDR_WIDTH  LSU destination
lsu_data  in  DATA_WIDTH  LSU load data
lsu_ready  out  1  LSU request granted this cycle
rf_wen  out  1  register file write enable
rf_waddr  out  ADDR_WIDTH  register file write index
rf_wdata  out  DATA_WIDTH  register file write data
pending_cnt  out  ADDR_WIDTH+1  number of busy registers
wb_err  out  1  sticky: writeback to a register that is not busy

Behaviour:
- State: busy[2**ADDR_WIDTH-1:0], last_grant (0=EXU, 1=LSU), pending_cnt, wb_err.
- Reset (rst high at posedge): busy all 0, last_grant=1 (EXU wins the first conflict), pending_cnt=0, wb_err=0. While rst is high: issue_ready, exu_ready, lsu_ready and rf_wen are forced to 0, and rs*_hazard=0.
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Arbitration is combinational, with a 0-cycle grant:
  - Only one source valid: that source is granted.
  - Both sources valid: the source not equal to last_grant is granted (round-robin).
  - last_grant updates to the granted source at the posedge. It holds when there is no grant.
  - Exactly one of exu_ready/lsu_ready is 1 when any request is valid. Both are 0 when no request is valid.
  - A requester holds valid, rd and data stable until granted.
- Write port outputs:
  - rf_waddr and rf_wdata come from the granted source; rf_wen = grant && rd!=0.
  - Writes to x0 are accepted (ready=1) but never reach the register file.
  - When there is no grant, rf_wen=0 and rf_waddr/rf_wdata=0.
- Hazards:
  - rsN_hazard = busy[rsN_addr] && rsN_addr!=0, computed from registered busy only.
  - A writeback granted in cycle T clears the hazard from cycle T+1. There is no bypass.
- Issue:
  - issue_ready = !busy[issue_rd] || issue_rd==0, using registered busy only.
  - A same-cycle writeback clearing issue_rd still stalls the issue in that cycle.
  - An accepted issue with rd!=0 sets busy[rd] at the posedge. An issue with rd==0 changes nothing.
- Busy update at posedge: set from the accepted issue, clear from the granted writeback with rd!=0.
  - Different registers: both updates apply.
  - Same register in the same cycle cannot occur, because issue_ready is 0 while that register is busy.
- pending_cnt changes as +1 for a set only, -1 for a clear only, and 0 for set+clear or neither. It always equals popcount(busy).
- wb_err: set at the posedge when a granted writeback has rd!=0 and busy[rd]==0. The write is still performed. wb_err stays set until rst.
- Reset mid-operation drops all pending state. Outstanding writebacks arriving after reset are written and flag wb_err.

Test Plan:
1. Reset, then idle → all readies 0 during rst. After rst: pending_cnt=0, wb_err=0, rs1_hazard=rs2_hazard=0, issue_ready=1.
2. Issue rd=5 (accepted), next cycle rs1_addr=5 → rs1_hazard=1, pending_cnt=1. EXU writeback rd=5, data=0xDEAD → same cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEAD, rs1_hazard still 1. Next cycle rs1_hazard=0, pending_cnt=0.
3. Issue rd=3 and rd=7 in turn, then EXU(rd=3) and LSU(rd=7) both valid for 2 cycles → cycle 1 EXU granted, cycle 2 LSU granted. Then both re-raised (rd=0) → EXU granted (alternation continues). wb_err=0.
4. busy[9]=1, issue rd=9 → issue_ready=0 until the cycle after the writeback of rd=9. In the writeback cycle itself issue_ready stays 0.
5. LSU writeback rd=0, data=0x1234 → lsu_ready=1, rf_wen=0, busy and pending_cnt unchanged. Issue rd=0 → issue_ready=1, pending_cnt unchanged.
6. Issue rd=4 and EXU writeback rd=2 (busy) in the same cycle → pending_cnt unchanged, busy[4]=1, busy[2]=0. Then EXU writeback rd=11 (not busy) → write performed, wb_err=1 and stays 1 until rst.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller and scoreboard for the general-purpose register file.
// Two writeback sources (EXU and LSU) share the register file's single write
// port through a round-robin arbiter with a same-cycle grant. A busy bit per
// register records in-flight writes. Decode uses these bits for read-after-write
// hazards and for write-after-write issue stalls.

module regfile_wb_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,

    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_hazard,
    output logic                  rs2_hazard,

    input  logic                  exu_valid,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    output logic                  exu_ready,

    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,

    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,

    output logic [ADDR_WIDTH:0]   pending_cnt,
    output logic                  wb_err
);

    localparam int NREGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

    // Identity of the source that won the most recent grant.
    typedef enum logic {
        SRC_EXU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    // Registered state
    logic [NREGS-1:0]      busy;
    src_e                  last_grant;

    // Next-state values
    logic [NREGS-1:0]      busy_nxt;
    logic [NREGS-1:0]      set_mask;
    logic [NREGS-1:0]      clr_mask;
    src_e                  last_grant_nxt;
    logic [ADDR_WIDTH:0]   pending_cnt_nxt;
    logic                  wb_err_nxt;

    // Arbitration and writeback datapath
    logic                  exu_gnt;
    logic                  lsu_gnt;
    logic                  wb_gnt;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_rd_busy;
    logic                  wb_clr;
    logic                  issue_set;

    // Round-robin arbiter: a lone requester always wins. Under contention the
    // source that did not win last time wins. Reset blocks every grant.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves a value unassigned and infers a latch.
        exu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (!rst) begin
            if (exu_valid && lsu_valid) begin
                if (last_grant == SRC_LSU) begin
                    exu_gnt = 1'b1;
                end else begin
                    lsu_gnt = 1'b1;
                end
            end else begin
                exu_gnt = exu_valid;
                lsu_gnt = lsu_valid;
            end
        end
    end

    assign exu_ready = exu_gnt;
    assign lsu_ready = lsu_gnt;
    assign wb_gnt    = exu_gnt | lsu_gnt;

    // Steer the granted source onto the write port. An idle port drives zeros.
    always_comb begin
        wb_rd   = '0;
        wb_data = '0;
        if (exu_gnt) begin
            wb_rd   = exu_rd;
            wb_data = exu_data;
        end else if (lsu_gnt) begin
            wb_rd   = lsu_rd;
            wb_data = lsu_data;
        end
    end

    // A write to x0 is accepted from the source but never reaches the file.
    assign rf_wen   = wb_gnt && (wb_rd != '0);
    assign rf_waddr = wb_rd;
    assign rf_wdata = wb_data;

    // Decode-side views use only registered busy. A writeback in flight this
    // cycle does not clear a hazard or an issue stall until the next cycle.
    assign rs1_hazard  = !rst && busy[rs1_addr] && (rs1_addr != '0);
    assign rs2_hazard  = !rst && busy[rs2_addr] && (rs2_addr != '0);
    assign issue_ready = !rst && (!busy[issue_rd] || (issue_rd == '0));

    assign wb_rd_busy = busy[wb_rd];
    assign issue_set  = issue_valid && issue_ready && (issue_rd != '0);
    // Only a real clear changes the count, so it stays equal to popcount(busy)
    // even when a stray writeback targets an idle register.
    assign wb_clr     = rf_wen && wb_rd_busy;

    // Scoreboard next state: busy set/clear masks, pending count, error flag.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_set) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (wb_clr) begin
            clr_mask[wb_rd] = 1'b1;
        end
        // Issue and clear can never hit the same register, because issue_ready
        // is low while that register is busy.
        busy_nxt = (busy | set_mask) & ~clr_mask;

        pending_cnt_nxt = pending_cnt;
        case ({issue_set, wb_clr})
            2'b10:   pending_cnt_nxt = pending_cnt + CNT_ONE;
            2'b01:   pending_cnt_nxt = pending_cnt - CNT_ONE;
            default: pending_cnt_nxt = pending_cnt;
        endcase

        // A write to a register with no outstanding issue indicates lost
        // bookkeeping, for example a writeback that outlived a reset. The data
        // is still written. The flag records the event until the next reset.
        wb_err_nxt = wb_err | (rf_wen && !wb_rd_busy);

        last_grant_nxt = last_grant;
        if (exu_gnt) begin
            last_grant_nxt = SRC_EXU;
        end else if (lsu_gnt) begin
            last_grant_nxt = SRC_LSU;
        end
    end

    // State register with synchronous reset. After reset, last_grant points at
    // the LSU, so the EXU wins the first conflict.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before the edge, whatever the statement order.
        if (rst) begin
            // busy is a flop vector, not a RAM, so clearing it in one cycle is cheap.
            busy        <= '0;
            last_grant  <= SRC_LSU;
            pending_cnt <= '0;
            wb_err      <= 1'b0;
        end else begin
            busy        <= busy_nxt;
            last_grant  <= last_grant_nxt;
            pending_cnt <= pending_cnt_nxt;
            wb_err      <= wb_err_nxt;
        end
    end

    // Structural invariants of the scoreboard and arbiter.
    a_one_grant : assert property (@(posedge clk) disable iff (rst)
        !(exu_ready && lsu_ready));
    a_grant_when_req : assert property (@(posedge clk) disable iff (rst)
        (exu_valid || lsu_valid) == (exu_ready || lsu_ready));
    a_cnt_popcount : assert property (@(posedge clk) disable iff (rst)
        int'(pending_cnt) == $countones(busy));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl. A cycle-by-cycle vector table covers
// reset, hazards, arbitration, x0 handling, issue stalls and wb_err. Hand-written
// loops then fill every register and drain them under contention.

module tb_regfile_wb_ctrl;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NV = 30;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          issue_ready;
    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
    logic          rs1_hazard;
    logic          rs2_hazard;
    logic          exu_valid;
    logic [AW-1:0] exu_rd;
    logic [DW-1:0] exu_data;
    logic          exu_ready;
    logic          lsu_valid;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          lsu_ready;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW:0]   pending_cnt;
    logic          wb_err;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_hazard  (rs1_hazard),
        .rs2_hazard  (rs2_hazard),
        .exu_valid   (exu_valid),
        .exu_rd      (exu_rd),
        .exu_data    (exu_data),
        .exu_ready   (exu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .pending_cnt (pending_cnt),
        .wb_err      (wb_err)
    );

    // One cycle of stimulus and the outputs expected before the closing edge.
    typedef struct {
        logic          rst;
        logic          iv;
        logic [AW-1:0] ird;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          ev;
        logic [AW-1:0] erd;
        logic [DW-1:0] ed;
        logic          lv;
        logic [AW-1:0] lrd;
        logic [DW-1:0] ld;
        logic          x_ir;
        logic          x_h1;
        logic          x_h2;
        logic          x_er;
        logic          x_lr;
        logic          x_wen;
        logic [AW-1:0] x_wa;
        logic [DW-1:0] x_wd;
        logic [AW:0]   x_pc;
        logic          x_err;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        issue_valid = 1'b0; issue_rd = '0;
        rs1_addr    = '0;   rs2_addr = '0;
        exu_valid   = 1'b0; exu_rd   = '0; exu_data = '0;
        lsu_valid   = 1'b0; lsu_rd   = '0; lsu_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exu_next;
        int lsu_next;
        logic exp_last;   // 1 = LSU won last
        logic ev, lv, xe, xl;
        int cyc;

        //                rst iv ird rs1 rs2 ev erd ed          lv lrd ld          ir h1 h2 er lr wen wa  wd          pc err
        vecs[0]  = '{1'b1,1'b1,5'd5, 5'd5, 5'd9,1'b1,5'd1, 64'hAA,    1'b1,5'd2,64'hBB,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd0,1'b0};
        vecs[1]  = '{1'b0,1'b0,5'd0, 5'd5, 5'd9,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd0,1'b0};
        vecs[2]  = '{1'b0,1'b1,5'd5, 5'd0, 5'd0,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd0,1'b0};
        vecs[3]  = '{1'b0,1'b0,5'd0, 5'd5, 5'd0,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd1,1'b0};
        vecs[4]  = '{1'b0,1'b0,5'd0, 5'd5, 5'd0,1'b1,5'd5, 64'hDEAD,  1'b0,5'd0,64'h0,     1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,5'd5, 64'hDEAD,  6'd1,1'b0};
        vecs[5]  = '{1'b0,1'b0,5'd0, 5'd5, 5'd0,1'b0,5'd0, 64'h0,     1'b1,5'd0,64'h1234,  1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,5'd0, 64'h1234,  6'd0,1'b0};
        vecs[6]  = '{1'b0,1'b1,5'd3, 5'd0, 5'd0,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd0,1'b0};
        vecs[7]  = '{1'b0,1'b1,5'd7, 5'd0, 5'd0,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd1,1'b0};
        vecs[8]  = '{1'b0,1'b0,5'd0, 5'd3, 5'd7,1'b1,5'd3, 64'h33,    1'b1,5'd7,64'h77,    1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,5'd3, 64'h33,    6'd2,1'b0};
        vecs[9]  = '{1'b0,1'b0,5'd0, 5'd3, 5'd7,1'b1,5'd3, 64'h33,    1'b1,5'd7,64'h77,    1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,5'd7, 64'h77,    6'd1,1'b0};
        vecs[10] = '{1'b0,1'b0,5'd0, 5'd3, 5'd7,1'b1,5'd0, 64'h10,    1'b1,5'd0,64'h20,    1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0, 64'h10,    6'd0,1'b0};
        vecs[11] = '{1'b0,1'b1,5'd9, 5'd0, 5'd0,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd0,1'b0};
        vecs[12] = '{1'b0,1'b1,5'd9, 5'd9, 5'd0,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd1,1'b0};
        vecs[13] = '{1'b0,1'b1,5'd9, 5'd9, 5'd0,1'b1,5'd9, 64'h99,    1'b0,5'd0,64'h0,     1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,5'd9, 64'h99,    6'd1,1'b0};
        vecs[14] = '{1'b0,1'b1,5'd9, 5'd9, 5'd0,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd0,1'b0};
        vecs[15] = '{1'b0,1'b0,5'd0, 5'd9, 5'd0,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd1,1'b0};
        vecs[16] = '{1'b0,1'b1,5'd0, 5'd0, 5'd0,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd1,1'b0};
        vecs[17] = '{1'b0,1'b0,5'd0, 5'd0, 5'd0,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd1,1'b0};
        vecs[18] = '{1'b0,1'b1,5'd2, 5'd0, 5'd0,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd1,1'b0};
        vecs[19] = '{1'b0,1'b1,5'd4, 5'd0, 5'd2,1'b1,5'd2, 64'h22,    1'b0,5'd0,64'h0,     1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,5'd2, 64'h22,    6'd2,1'b0};
        vecs[20] = '{1'b0,1'b0,5'd0, 5'd4, 5'd2,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd2,1'b0};
        vecs[21] = '{1'b0,1'b0,5'd0, 5'd0, 5'd0,1'b1,5'd11,64'hB,     1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,5'd11,64'hB,     6'd2,1'b0};
        vecs[22] = '{1'b0,1'b0,5'd0, 5'd0, 5'd0,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd2,1'b1};
        vecs[23] = '{1'b0,1'b0,5'd0, 5'd9, 5'd0,1'b0,5'd0, 64'h0,     1'b1,5'd9,64'h9999,  1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,5'd9, 64'h9999,  6'd2,1'b1};
        vecs[24] = '{1'b0,1'b0,5'd0, 5'd9, 5'd4,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd1,1'b1};
        vecs[25] = '{1'b1,1'b1,5'd7, 5'd4, 5'd0,1'b1,5'd4, 64'h44,    1'b0,5'd0,64'h0,     1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd1,1'b1};
        vecs[26] = '{1'b0,1'b0,5'd0, 5'd4, 5'd0,1'b1,5'd4, 64'h44,    1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,5'd4, 64'h44,    6'd0,1'b0};
        vecs[27] = '{1'b0,1'b0,5'd0, 5'd4, 5'd0,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd0,1'b1};
        vecs[28] = '{1'b1,1'b0,5'd0, 5'd0, 5'd0,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd0,1'b1};
        vecs[29] = '{1'b0,1'b0,5'd0, 5'd0, 5'd0,1'b0,5'd0, 64'h0,     1'b0,5'd0,64'h0,     1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 64'h0,     6'd0,1'b0};

        // Power-up reset: two edges with rst high and idle inputs.
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);

        // Table: drive just after the edge, compare mid-cycle, then take the edge.
        for (int i = 0; i < NV; i++) begin
            #1;
            rst         = vecs[i].rst;
            issue_valid = vecs[i].iv;  issue_rd = vecs[i].ird;
            rs1_addr    = vecs[i].rs1; rs2_addr = vecs[i].rs2;
            exu_valid   = vecs[i].ev;  exu_rd   = vecs[i].erd; exu_data = vecs[i].ed;
            lsu_valid   = vecs[i].lv;  lsu_rd   = vecs[i].lrd; lsu_data = vecs[i].ld;
            #2;
            check($sformatf("v%0d issue_ready", i), 64'(issue_ready), 64'(vecs[i].x_ir));
            check($sformatf("v%0d rs1_hazard", i),  64'(rs1_hazard),  64'(vecs[i].x_h1));
            check($sformatf("v%0d rs2_hazard", i),  64'(rs2_hazard),  64'(vecs[i].x_h2));
            check($sformatf("v%0d exu_ready", i),   64'(exu_ready),   64'(vecs[i].x_er));
            check($sformatf("v%0d lsu_ready", i),   64'(lsu_ready),   64'(vecs[i].x_lr));
            check($sformatf("v%0d rf_wen", i),      64'(rf_wen),      64'(vecs[i].x_wen));
            check($sformatf("v%0d rf_waddr", i),    64'(rf_waddr),    64'(vecs[i].x_wa));
            check($sformatf("v%0d rf_wdata", i),    rf_wdata,         vecs[i].x_wd);
            check($sformatf("v%0d pending_cnt", i), 64'(pending_cnt), 64'(vecs[i].x_pc));
            check($sformatf("v%0d wb_err", i),      64'(wb_err),      64'(vecs[i].x_err));
            @(posedge clk);
        end

        // Fill every architectural register. The counter must reach its top value.
        for (int r = 1; r < 32; r++) begin
            #1;
            drive_idle();
            issue_valid = 1'b1;
            issue_rd    = AW'(r);
            #2;
            check($sformatf("fill%0d issue_ready", r), 64'(issue_ready), 64'd1);
            check($sformatf("fill%0d pending_cnt", r), 64'(pending_cnt), 64'(r - 1));
            @(posedge clk);
        end
        #1;
        drive_idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd31;
        rs1_addr    = 5'd31;
        rs2_addr    = 5'd1;
        #2;
        check("full pending_cnt", 64'(pending_cnt), 64'd31);
        check("full issue_ready rd31", 64'(issue_ready), 64'd0);
        check("full rs1_hazard", 64'(rs1_hazard), 64'd1);
        check("full rs2_hazard", 64'(rs2_hazard), 64'd1);
        issue_rd = 5'd0;
        #1;
        check("full issue_ready rd0", 64'(issue_ready), 64'd1);
        @(posedge clk);

        // Drain: EXU retires odd registers, LSU even ones. Each side holds its
        // request until the expected grant. Under contention grants must alternate.
        exu_next = 1;
        lsu_next = 2;
        exp_last = 1'b1;
        cyc      = 0;
        while ((exu_next <= 31 || lsu_next <= 30) && cyc < 40) begin
            #1;
            drive_idle();
            ev = (exu_next <= 31);
            lv = (lsu_next <= 30);
            exu_valid = ev; exu_rd = AW'(exu_next); exu_data = 64'h100 + 64'(exu_next);
            lsu_valid = lv; lsu_rd = AW'(lsu_next); lsu_data = 64'h200 + 64'(lsu_next);
            xe = ev && (!lv || exp_last);
            xl = lv && !xe;
            #2;
            check($sformatf("drain%0d exu_ready", cyc), 64'(exu_ready), 64'(xe));
            check($sformatf("drain%0d lsu_ready", cyc), 64'(lsu_ready), 64'(xl));
            check($sformatf("drain%0d rf_waddr", cyc), 64'(rf_waddr),
                  xe ? 64'(exu_next) : 64'(lsu_next));
            check($sformatf("drain%0d rf_wdata", cyc), rf_wdata,
                  xe ? 64'h100 + 64'(exu_next) : 64'h200 + 64'(lsu_next));
            if (xe) begin
                exu_next += 2;
                exp_last  = 1'b0;
            end else if (xl) begin
                lsu_next += 2;
                exp_last  = 1'b1;
            end
            cyc++;
            @(posedge clk);
        end
        check("drain finished within budget", 64'(cyc < 40), 64'd1);
        #1;
        drive_idle();
        rs1_addr = 5'd31;
        rs2_addr = 5'd30;
        #2;
        check("drained pending_cnt", 64'(pending_cnt), 64'd0);
        check("drained wb_err", 64'(wb_err), 64'd0);
        check("drained rs1_hazard", 64'(rs1_hazard), 64'd0);
        check("drained rs2_hazard", 64'(rs2_hazard), 64'd0);
        @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
